// File: rtl/cpu_pio_in.sv
// Avalon-MM input PIO: synchronised input bus, sticky per-bit edge capture, masked level IRQ.
// Zero-latency combinational read mux; writes take effect at the clock edge, no wait states.
module cpu_pio_in #(
  parameter int WIDTH     = 11,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q, sync2_q, data_d1_q;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_term;
  logic [1:0]       arm_cnt_q, arm_cnt_d;
  logic             wr_en, armed;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign armed        = (arm_cnt_q == 2'd3);
  assign unused_wdata = ^writedata;

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_term = sync2_q & ~data_d1_q;
      1:       edge_term = ~sync2_q & data_d1_q;
      default: edge_term = sync2_q ^ data_d1_q;
    endcase
  end

  always_comb begin
    arm_cnt_d      = armed ? arm_cnt_q : arm_cnt_q + 2'd1;
    irq_mask_d     = irq_mask_q;
    edge_capture_d = edge_capture_q;
    if (wr_en && address == 2'd2)
      irq_mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == 2'd3)
      edge_capture_d = edge_capture_q & ~writedata[WIDTH-1:0];
    // A new edge is OR-ed in after the clear so it wins over a same-cycle W1C.
    if (armed)
      edge_capture_d = edge_capture_d | edge_term;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      data_d1_q      <= '0;
      edge_capture_q <= '0;
      irq_mask_q     <= '0;
      arm_cnt_q      <= 2'd0;
    end else begin
      sync1_q        <= in_port;
      sync2_q        <= sync1_q;
      data_d1_q      <= sync2_q;
      edge_capture_q <= edge_capture_d;
      irq_mask_q     <= irq_mask_d;
      arm_cnt_q      <= arm_cnt_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = sync2_q;
      2'd2:    readdata[WIDTH-1:0] = irq_mask_q;
      2'd3:    readdata[WIDTH-1:0] = edge_capture_q;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_cpu_pio_in.sv
// Scoreboard bench for cpu_pio_in: rising-edge instance (dut1) and any-edge instance (dut2) on one bus.
module tb_cpu_pio_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [10:0] in_port;
  logic [31:0] readdata1, readdata2;
  logic        irq1, irq2;

  logic        chk_req;
  logic [31:0] exp_rd_q[$];
  logic        exp_irq_q[$];
  int          sel_q[$];
  int          id_q[$];
  int          chk_id = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  cpu_pio_in #(.WIDTH(11), .EDGE_TYPE(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata1), .irq(irq1)
  );

  cpu_pio_in #(.WIDTH(11), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata2), .irq(irq2)
  );

  // Monitor: one pop per check request, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_req) begin
      if (exp_rd_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got a check request with no expected entry, required one");
      end else begin
        logic [31:0] er, gr;
        logic        ei, gi;
        int          sel, id;
        er  = exp_rd_q.pop_front();
        ei  = exp_irq_q.pop_front();
        sel = sel_q.pop_front();
        id  = id_q.pop_front();
        gr  = (sel == 1) ? readdata2 : readdata1;
        gi  = (sel == 1) ? irq2 : irq1;
        n_tests++;
        if (gr !== er) begin
          n_fail++;
          $display("FAIL chk%0d_dut%0d_rd addr=%0d: got %h, required %h", id, sel + 1, address, gr, er);
        end
        n_tests++;
        if (gi !== ei) begin
          n_fail++;
          $display("FAIL chk%0d_dut%0d_irq: got %b, required %b", id, sel + 1, gi, ei);
        end
      end
    end
  end

  task automatic chk(input int sel, input logic [1:0] a, input logic [31:0] er, input logic ei);
    address = a;
    exp_rd_q.push_back(er);
    exp_irq_q.push_back(ei);
    sel_q.push_back(sel);
    id_q.push_back(chk_id);
    chk_id++;
    chk_req = 1'b1;
    @(posedge clk); #1;
    chk_req = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 11'h7FF;
    chk_req    = 1'b0;
    idle(2);

    // Reset state for every address, both instances.
    for (int a = 0; a < 4; a++) begin
      chk(0, 2'(a), 32'h0, 1'b0);
      chk(1, 2'(a), 32'h0, 1'b0);
    end

    // Release with all inputs high: data appears after two edges, nothing is captured.
    reset_n = 1'b1;
    chk(0, 2'd0, 32'h0, 1'b0);
    chk(0, 2'd0, 32'h0, 1'b0);
    chk(0, 2'd0, 32'h0000_07FF, 1'b0);
    chk(1, 2'd3, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) chk(0, 2'd3, 32'h0, 1'b0);
    chk(1, 2'd3, 32'h0, 1'b0);

    // Rising edge on bit 0 with mask 1.
    in_port = 11'h000;
    idle(4);
    chk(0, 2'd3, 32'h0, 1'b0);
    chk(0, 2'd0, 32'h0, 1'b0);
    wr(2'd2, 32'h1);
    in_port = 11'h001;
    chk(0, 2'd0, 32'h0, 1'b0);
    chk(0, 2'd0, 32'h0, 1'b0);
    chk(0, 2'd0, 32'h1, 1'b0);
    chk(0, 2'd3, 32'h1, 1'b1);
    in_port = 11'h000;
    for (int i = 0; i < 4; i++) chk(0, 2'd3, 32'h1, 1'b1);
    chk(0, 2'd0, 32'h0, 1'b1);

    // Build capture 0x005, then W1C bit 0.
    in_port = 11'h004;
    for (int i = 0; i < 3; i++) chk(0, 2'd3, 32'h1, 1'b1);
    chk(0, 2'd3, 32'h5, 1'b1);
    wr(2'd3, 32'h1);
    chk(0, 2'd3, 32'h4, 1'b0);

    // New rising edge on bit 2 lands on the same edge as its W1C: set wins.
    in_port = 11'h000;
    idle(4);
    chk(0, 2'd3, 32'h4, 1'b0);
    in_port = 11'h004;
    idle(2);
    wr(2'd3, 32'h4);
    chk(0, 2'd3, 32'h4, 1'b0);
    wr(2'd3, 32'h4);
    chk(0, 2'd3, 32'h0, 1'b0);

    // Mask behaviour and read mux.
    wr(2'd2, 32'h0);
    in_port = 11'h007;
    for (int i = 0; i < 3; i++) chk(0, 2'd3, 32'h0, 1'b0);
    chk(0, 2'd3, 32'h3, 1'b0);
    wr(2'd2, 32'h7FF);
    chk(0, 2'd3, 32'h3, 1'b1);
    chk(0, 2'd2, 32'h0000_07FF, 1'b1);
    chk(0, 2'd1, 32'h0, 1'b1);
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    chk(0, 2'd2, 32'h0000_07FF, 1'b1);
    chk(0, 2'd3, 32'h3, 1'b1);
    chk(0, 2'd0, 32'h7, 1'b1);
    address   = 2'd2;
    writedata = 32'h0;
    write_n   = 1'b0;
    @(posedge clk); #1;
    write_n   = 1'b1;
    chk(0, 2'd2, 32'h0000_07FF, 1'b1);
    wr(2'd2, 32'h0);
    chk(0, 2'd3, 32'h3, 1'b0);
    wr(2'd2, 32'h7FF);
    chk(0, 2'd3, 32'h3, 1'b1);

    // Any-edge instance: bit 10 captured on both transitions.
    wr(2'd3, 32'hFFFF_FFFF);
    chk(1, 2'd3, 32'h0, 1'b0);
    chk(0, 2'd3, 32'h0, 1'b0);
    in_port = 11'h407;
    for (int i = 0; i < 3; i++) chk(1, 2'd3, 32'h0, 1'b0);
    chk(1, 2'd3, 32'h400, 1'b1);
    wr(2'd3, 32'h400);
    in_port = 11'h007;
    for (int i = 0; i < 3; i++) chk(1, 2'd3, 32'h0, 1'b0);
    chk(1, 2'd3, 32'h400, 1'b1);
    chk(0, 2'd3, 32'h0, 1'b0);

    // Asynchronous reset mid-capture, then re-arm with inputs held.
    reset_n = 1'b0;
    chk(1, 2'd3, 32'h0, 1'b0);
    chk(1, 2'd2, 32'h0, 1'b0);
    chk(0, 2'd2, 32'h0, 1'b0);
    reset_n = 1'b1;
    idle(5);
    chk(1, 2'd3, 32'h0, 1'b0);
    chk(1, 2'd0, 32'h7, 1'b0);
    chk(0, 2'd3, 32'h0, 1'b0);

    idle(2);
    n_tests++;
    if (exp_rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_rd_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
